// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_pkg
// Purpose  : Shared defines for the execute stage: ALU ops, mul/div op
//            encoding, and mul/div FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Bit 2 separates divide (1) from multiply (0); bit 1 picks REM over DIV.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic op_signed_a(input md_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input md_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Request/result handshake bundle between the pipeline and the
//            iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] y;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, y
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV-style multiply/divide, one bit per cycle.
//            Divider is built only when MULDIV_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input wire           clk,
    input wire           reset,
    muldiv_unit_if.slave bus
);

    localparam int              CNT_W     = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    md_state_e         w_state_nxt;
    md_op_e            r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_y;
    logic              r_sa;
    logic              r_sb;

    md_op_e            w_op;
    logic              w_accept;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_direct;
    logic [XLEN-1:0]   w_direct_y;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN-1:0]   w_mul_hi;
    logic [XLEN-1:0]   w_mul_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_fix_y;

    assign w_op     = md_op_e'(bus.op);
    assign w_accept = bus.in_valid && (r_state == ST_IDLE) && !bus.kill;
    assign w_sa     = bus.a[XLEN-1] && op_signed_a(w_op);
    assign w_sb     = bus.b[XLEN-1] && op_signed_b(w_op);
    assign w_mag_a  = w_sa ? -bus.a : bus.a;
    assign w_mag_b  = w_sb ? -bus.b : bus.b;

`ifdef MULDIV_DIV_EN
    logic            w_b_zero;
    logic            w_ovf;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic [XLEN-1:0] w_div_rem;
    logic [XLEN-1:0] w_div_quo;

    assign w_b_zero   = (bus.b == '0);
    assign w_ovf      = w_op[2] && op_signed_b(w_op) && (bus.a == C_MIN_NEG) && (bus.b == '1);
    assign w_direct   = w_op[2] && (w_b_zero || w_ovf);
    // Divide by zero: quotient all-ones, remainder = a. Overflow: quotient a, remainder 0.
    assign w_direct_y = w_b_zero ? (w_op[1] ? bus.a : '1)
                                 : (w_op[1] ? '0 : bus.a);

    // Restoring step: remainder in r_hi, dividend shifts out of r_lo as quotient shifts in.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_rem   = w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
    assign w_div_quo   = {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
`else
    logic w_unused_min;

    assign w_unused_min = ^C_MIN_NEG;
    assign w_direct     = w_op[2];
    assign w_direct_y   = '0;
`endif

    // Shift-add: {r_hi, r_lo} is the running product, multiplier bits consumed from r_lo[0].
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[XLEN:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (r_sa ^ r_sb) ? -w_prod : w_prod;

    always_comb begin
        w_fix_y = '0;
        case (r_op)
            OP_MUL:                       w_fix_y = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_y = w_prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:              w_fix_y = (r_sa ^ r_sb) ? -r_lo : r_lo;
            OP_REM, OP_REMU:              w_fix_y = r_sa ? -r_hi : r_hi;
`endif
            default:                      w_fix_y = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.kill) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.in_valid) w_state_nxt = w_direct ? ST_DONE : ST_BUSY;
                ST_BUSY: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FIX;
                ST_FIX:  w_state_nxt = ST_DONE;
                ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= OP_MUL;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_opb <= '0;
            r_y   <= '0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
        end else if (bus.kill) begin
            r_cnt <= '0;
            r_y   <= '0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_hi  <= '0;
            r_lo  <= w_mag_a;
            r_opb <= w_mag_b;
            r_cnt <= CNT_W'(XLEN);
            r_y   <= w_direct_y;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt - CNT_W'(1);
`ifdef MULDIV_DIV_EN
            if (r_op[2]) begin
                r_hi <= w_div_rem;
                r_lo <= w_div_quo;
            end else
`endif
            begin
                r_hi <= w_mul_hi;
                r_lo <= w_mul_lo;
            end
        end else if (r_state == ST_FIX) begin
            r_y <= w_fix_y;
        end else if ((r_state == ST_DONE) && bus.out_ready) begin
            r_y <= '0;
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.y         = (r_state == ST_DONE) ? r_y : '0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed vector table plus handshake/kill/reset sequences for
//            muldiv_unit at XLEN=32, with or without MULDIV_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int NV   = 22;

    typedef struct {
        string       nm;
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          lat;   // rising edges after the acceptance edge until out_valid
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    vec_t vecs [NV];

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run_op(input string nm, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_y, input int exp_lat,
                          input int hold, input bit kill_end);
        int lat;
        @(negedge clk);
        chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " y"}, bus.y, exp_y);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, " hold y"}, bus.y, exp_y);
            chk({nm, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({nm, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        if (kill_end) bus.kill = 1'b1;
        else          bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
        chk({nm, " release out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, " release y"}, bus.y, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_y;
        int          exp_lat;
        bit          seen;

        vecs[0]  = '{"mul_7_m3",      OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{"mulhu_ones",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[2]  = '{"mulh_ones",     OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[3]  = '{"mulhsu_ones",   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{"mul_shift",     OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33};
        vecs[5]  = '{"mulh_minmin",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[6]  = '{"mulhu_mixed",   OP_MULHU,  32'h80000000, 32'h00000004, 32'h00000002, 33};
        vecs[7]  = '{"mulh_neg_pos",  OP_MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
        vecs[8]  = '{"div_m7_2",      OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[9]  = '{"rem_m7_2",      OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[10] = '{"divu_5_0",      OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 0};
        vecs[11] = '{"remu_5_0",      OP_REMU,   32'd5,        32'd0,        32'd5,        0};
        vecs[12] = '{"div_ovf",       OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
        vecs[13] = '{"rem_ovf",       OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};
        vecs[14] = '{"divu_100_7",    OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
        vecs[15] = '{"remu_100_7",    OP_REMU,   32'd100,      32'd7,        32'd2,        33};
        vecs[16] = '{"div_7_m2",      OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[17] = '{"rem_7_m2",      OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
        vecs[18] = '{"div_m5_0",      OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 0};
        vecs[19] = '{"rem_m5_0",      OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 0};
        vecs[20] = '{"divu_min_ones", OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
        vecs[21] = '{"div_min_1",     OP_DIV,    32'h80000000, 32'd1,        32'h80000000, 33};

        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset y", bus.y, 32'd0);

        for (int i = 0; i < NV; i++) begin
            exp_y   = vecs[i].y;
            exp_lat = vecs[i].lat;
`ifndef MULDIV_DIV_EN
            if (vecs[i].op[2]) begin
                exp_y   = '0;
                exp_lat = 0;
            end
`endif
            run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, exp_y, exp_lat, 0, 1'b0);
        end

        // Result held while the consumer stalls
        run_op("stall_mul", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 5, 1'b0);

        // Kill ten cycles into BUSY
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("kill busy in_ready", 32'(bus.in_ready), 32'd0);
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        chk("kill idle in_ready", 32'(bus.in_ready), 32'd1);
        chk("kill out_valid", 32'(bus.out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("kill no result", 32'(seen), 32'd0);
        run_op("post_kill_mul", OP_MUL, 32'd3, 32'd5, 32'd15, 33, 0, 1'b0);

        // Kill beats acceptance
        @(negedge clk);
        bus.in_valid = 1'b1; bus.kill = 1'b1; bus.op = OP_DIVU; bus.a = 32'd5; bus.b = 32'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.kill = 1'b0;
        chk("kill vs accept in_ready", 32'(bus.in_ready), 32'd1);
        chk("kill vs accept out_valid", 32'(bus.out_valid), 32'd0);

        // Kill while DONE discards the result
        run_op("kill_done", OP_MULHU, 32'h00010000, 32'h00010000, 32'd1, 33, 2, 1'b1);
        chk("kill_done in_ready", 32'(bus.in_ready), 32'd1);

        // Reset mid-operation
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = OP_MULH; bus.a = 32'd9; bus.b = 32'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset in_ready", 32'(bus.in_ready), 32'd1);
        chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset y", bus.y, 32'd0);
        run_op("post_reset_mul", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 33, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand/result width; legal values are even and at least 8.
REQ-002 SHALL provide clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide in_valid  input  1  request present.
REQ-005 SHALL provide in_ready  output  1  unit can accept a request.
REQ-006 SHALL provide op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL provide a  input  XLEN  operand a (multiplicand/dividend).
REQ-008 SHALL provide b  input  XLEN  operand b (multiplier/divisor).
REQ-009 SHALL provide kill  input  1  pipeline flush; abort any operation.
REQ-010 SHALL provide out_valid  output  1  result y valid.
REQ-011 SHALL provide out_ready  input  1  consumer takes result.
REQ-012 SHALL provide y  output  XLEN  result.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, FIX, DONE.
REQ-014 SHALL assert in_ready only in IDLE; a request is accepted on an edge with in_valid && in_ready && !kill.
REQ-015 SHALL latch op, a, b on acceptance; later input changes have no effect until the result is consumed.
REQ-016 SHALL on normal acceptance enter BUSY and run exactly XLEN iterations, one bit per cycle: shift-add for multiply, restoring shift-subtract on magnitudes for divide.
REQ-017 SHALL after BUSY spend one FIX cycle applying sign correction and high/low word selection, then enter DONE.
REQ-018 SHALL assert out_valid in DONE only; normal latency from acceptance edge to out_valid high is XLEN+1 cycles.
REQ-019 SHALL hold y and out_valid stable in DONE until out_ready is high; on that edge return to IDLE.
REQ-020 SHALL compute MUL as low XLEN bits, MULH/MULHSU/MULHU as high XLEN bits of the 2*XLEN signed*signed, signed*unsigned, unsigned*unsigned product.
REQ-021 SHALL on divide by zero give DIV/DIVU all-ones and REM/REMU equal to a, going directly to DONE (out_valid one cycle after acceptance).
REQ-022 SHALL on signed overflow (a = most negative, b = all-ones) give DIV = a and REM = 0, going directly to DONE.
REQ-023 SHALL give remainder the sign of the dividend and quotient truncation toward zero.
REQ-024 SHALL on kill in any state return to IDLE on the next edge, deassert out_valid, and discard the result; kill has priority over acceptance and out_ready.
REQ-025 SHALL drive y = 0 whenever out_valid is low.

Reset
REQ-026 SHALL on reset enter IDLE with out_valid 0, in_ready 1 after the edge, y 0, iteration counter and datapath registers cleared; reset mid-operation aborts it silently.

Configuration
REQ-027 SHALL with MULDIV_DIV_EN defined implement ops 4-7 as in REQ-016 to REQ-023.
REQ-028 SHALL without MULDIV_DIV_EN omit divider logic; ops 4-7 go directly to DONE with y = 0 (one-cycle latency); multiply unaffected.

Structure
REQ-029 SHALL place the op encoding enum and the FSM state typedef in the shared defines package alongside existing ALU op codes.
REQ-030 SHALL keep the iteration counter width as $clog2(XLEN)+1, local to the module.
REQ-031 SHALL be a single module; no sub-module required.

Verification
REQ-032 SHALL verify XLEN=32 MUL a=7, b=-3 -> y=0xFFFFFFEB, out_valid exactly 33 cycles after acceptance.
REQ-033 SHALL verify MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> y=0xFFFFFFFE; MULH same operands -> y=0.
REQ-034 SHALL verify DIV a=-7, b=2 -> y=-3; REM same -> y=-1; DIVU a=5, b=0 -> 0xFFFFFFFF after 1 cycle.
REQ-035 SHALL verify DIV a=0x80000000, b=0xFFFFFFFF -> y=0x80000000; REM -> 0.
REQ-036 SHALL verify kill asserted 10 cycles into BUSY -> IDLE next edge, no out_valid; next request completes correctly.
REQ-037 SHALL verify out_ready held low 5 cycles in DONE -> y, out_valid stable; in_ready low throughout.
